fetch_decode: RTL and testbench

- Front-end stage directly upstream of the register file.
- Owns the program counter, addresses the instruction memory, latches the returned word into an instruction register, and decodes it into opcode and register addresses.
- Produces the write strobe that drives reg_file.
- Adds run control, stall, branch redirect and a HALT opcode, replacing the free-running PC increment.

---
 rtl/fetch_decode_pkg.sv | 26 ++
 rtl/fetch_decode.sv | 95 +++++++++
 tb/tb_fetch_decode.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, FSM encoding,
// and instruction field positions used by reg_file wiring and execute.
package fetch_decode_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;
  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;

  // Instruction layout: [15:12] opcode, [11:8] A, [7:4] B, [3:0] C
  localparam int OPC_LSB = 12;
  localparam int A_LSB   = 8;
  localparam int B_LSB   = 4;
  localparam int C_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fd_state_e;

  function automatic logic is_write_op(input logic [OPC_W-1:0] opc);
    return (opc != OPC_NOP) && (opc != OPC_HALT);
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, instruction memory addressing, instruction
// register, field decode and the reg_file write strobe.
//
// state | meaning
// IDLE  | waiting for run; no fetch on the edge that leaves IDLE
// FETCH | one action per edge: branch > stall > run drop > capture
// HALT  | HALT word captured; PC/IR frozen until clear
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 16,
  parameter int RA_W    = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               run,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic [OPC_W-1:0]   opcode,
  output logic [RA_W-1:0]    a_addr,
  output logic [RA_W-1:0]    b_addr,
  output logic [RA_W-1:0]    c_addr,
  output logic               load,
  output logic               halted
);

  fd_state_e          state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (br_valid) begin
          pc_d    = br_target;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (!run) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          ir_d    = imem_data;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          if (imem_data[OPC_LSB +: OPC_W] == OPC_HALT) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        // the HALT word is visible as valid for its first cycle only
        valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign opcode      = ir_q[OPC_LSB +: OPC_W];
  assign a_addr      = ir_q[A_LSB +: RA_W];
  assign b_addr      = ir_q[B_LSB +: RA_W];
  assign c_addr      = ir_q[C_LSB +: RA_W];
  assign load        = valid_q && is_write_op(opcode);
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a combinational instruction memory.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        clear, run, stall, br_valid;
  logic [3:0]  br_target;
  logic [3:0]  imem_addr, pc;
  logic [15:0] imem_data;
  logic        instr_valid, load, halted;
  logic [3:0]  opcode, a_addr, b_addr, c_addr;

  logic [15:0] imem [16];
  int vectors = 0;
  int errs    = 0;

  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk(clk), .clear(clear), .run(run), .stall(stall),
    .br_valid(br_valid), .br_target(br_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .instr_valid(instr_valid), .opcode(opcode),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .load(load), .halted(halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
    imem[0] = 16'h1234; imem[1] = 16'h2345; imem[2] = 16'h3456; imem[3] = 16'h4000;
    clear = 1'b0; run = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = 4'd0;
    step(); step();
    chk("rst_pc", 16'(pc), 16'h0);
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0);
    chk("rst_load", 16'(load), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);

    // basic run: IDLE edge first, then fetches
    clear = 1'b1; run = 1'b1;
    chk("run_pc0", 16'(pc), 16'h0);
    step();
    chk("idle_edge_pc", 16'(pc), 16'h0);
    chk("idle_edge_valid", 16'(instr_valid), 16'h0);
    step();
    chk("f1_pc", 16'(pc), 16'h1);
    chk("f1_imem_addr", 16'(imem_addr), 16'h1);
    chk("f1_opcode", 16'(opcode), 16'h1);
    chk("f1_a", 16'(a_addr), 16'h2);
    chk("f1_b", 16'(b_addr), 16'h3);
    chk("f1_c", 16'(c_addr), 16'h4);
    chk("f1_load", 16'(load), 16'h1);
    step();
    chk("f2_pc", 16'(pc), 16'h2);
    chk("f2_opcode", 16'(opcode), 16'h2);
    step();
    chk("f3_pc", 16'(pc), 16'h3);
    chk("f3_c", 16'(c_addr), 16'h6);

    // wrap from 15 to 0
    imem[15] = 16'h5ABC;
    br_valid = 1'b1; br_target = 4'd15;
    step();
    chk("br15_pc", 16'(pc), 16'hF);
    chk("br15_valid", 16'(instr_valid), 16'h0);
    chk("br15_load", 16'(load), 16'h0);
    br_valid = 1'b0;
    step();
    chk("wrap_pc", 16'(pc), 16'h0);
    chk("wrap_valid", 16'(instr_valid), 16'h1);
    chk("wrap_opcode", 16'(opcode), 16'h5);
    chk("wrap_a", 16'(a_addr), 16'hA);
    chk("wrap_b", 16'(b_addr), 16'hB);
    chk("wrap_c", 16'(c_addr), 16'hC);

    // stall three cycles at pc=5
    imem[4] = 16'h7321; imem[5] = 16'h8456;
    br_valid = 1'b1; br_target = 4'd4;
    step();
    br_valid = 1'b0;
    step();
    chk("pre_stall_pc", 16'(pc), 16'h5);
    chk("pre_stall_opcode", 16'(opcode), 16'h7);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", 16'(pc), 16'h5);
      chk("stall_opcode", 16'(opcode), 16'h7);
      chk("stall_load", 16'(load), 16'h1);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", 16'(pc), 16'h6);
    chk("unstall_opcode", 16'(opcode), 16'h8);

    // branch and stall together: branch wins
    imem[9] = 16'h9ABC;
    stall = 1'b1; br_valid = 1'b1; br_target = 4'd9;
    step();
    chk("brst_pc", 16'(pc), 16'h9);
    chk("brst_valid", 16'(instr_valid), 16'h0);
    chk("brst_load", 16'(load), 16'h0);
    stall = 1'b0; br_valid = 1'b0;
    step();
    chk("brst_next_pc", 16'(pc), 16'hA);
    chk("brst_next_opcode", 16'(opcode), 16'h9);
    chk("brst_next_a", 16'(a_addr), 16'hA);

    // run drops while stalled: stall wins, IDLE on first unstalled edge
    imem[10] = 16'h1111;
    stall = 1'b1; run = 1'b0;
    step();
    chk("rdst_pc", 16'(pc), 16'hA);
    chk("rdst_valid", 16'(instr_valid), 16'h1);
    stall = 1'b0;
    step();
    chk("rd_pc", 16'(pc), 16'hA);
    chk("rd_valid", 16'(instr_valid), 16'h0);
    chk("rd_load", 16'(load), 16'h0);
    run = 1'b1;
    step();
    chk("rerun_idle_pc", 16'(pc), 16'hA);
    step();
    chk("rerun_pc", 16'(pc), 16'hB);
    chk("rerun_opcode", 16'(opcode), 16'h1);

    // NOP then HALT
    imem[2] = 16'h0111; imem[3] = 16'hF000;
    br_valid = 1'b1; br_target = 4'd2;
    step();
    br_valid = 1'b0;
    step();
    chk("nop_pc", 16'(pc), 16'h3);
    chk("nop_valid", 16'(instr_valid), 16'h1);
    chk("nop_load", 16'(load), 16'h0);
    step();
    chk("halt_pc", 16'(pc), 16'h4);
    chk("halt_halted", 16'(halted), 16'h1);
    chk("halt_valid", 16'(instr_valid), 16'h1);
    chk("halt_load", 16'(load), 16'h0);
    br_valid = 1'b1; br_target = 4'd0; run = 1'b0;
    step();
    chk("halt2_pc", 16'(pc), 16'h4);
    chk("halt2_valid", 16'(instr_valid), 16'h0);
    chk("halt2_opcode", 16'(opcode), 16'hF);
    br_valid = 1'b0; run = 1'b1; stall = 1'b1;
    step();
    chk("halt3_pc", 16'(pc), 16'h4);
    chk("halt3_halted", 16'(halted), 16'h1);
    stall = 1'b0;
    clear = 1'b0;
    step();
    chk("halt_clr_pc", 16'(pc), 16'h0);
    chk("halt_clr_halted", 16'(halted), 16'h0);
    chk("halt_clr_opcode", 16'(opcode), 16'h0);

    // reset mid-run at pc=7
    imem[6] = 16'h2222;
    clear = 1'b1; run = 1'b1;
    step();
    br_valid = 1'b1; br_target = 4'd6;
    step();
    br_valid = 1'b0;
    step();
    chk("mid_pc", 16'(pc), 16'h7);
    chk("mid_valid", 16'(instr_valid), 16'h1);
    clear = 1'b0;
    step();
    chk("mid_rst_pc", 16'(pc), 16'h0);
    chk("mid_rst_valid", 16'(instr_valid), 16'h0);
    clear = 1'b1;
    step();
    chk("mid_idle_pc", 16'(pc), 16'h0);
    chk("mid_idle_valid", 16'(instr_valid), 16'h0);
    step();
    chk("mid_fetch_pc", 16'(pc), 16'h1);
    chk("mid_fetch_opcode", 16'(opcode), 16'h1);
    chk("mid_fetch_load", 16'(load), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
